// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master: accepts tagged read/write commands,
// streams write beats from a valid/ready port and returns read beats with tags.
module wb_burst_master #(
  parameter int DW     = 32,
  parameter int AW     = 26,
  parameter int TW     = 8,
  parameter int TO_CYC = 1024
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            sdr_init_done,
  output logic            busy,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [TW-1:0]   cmd_tag,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_sel,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic [TW-1:0]   rd_tag,
  output logic            rd_last,
  output logic            done_valid,
  output logic [TW-1:0]   done_tag,
  output logic            done_err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int SW  = DW / 8;
  localparam int WDW = $clog2(TO_CYC + 1);
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t          state_q;
  logic            cyc_q, stb_q, we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   dat_q;
  logic [SW-1:0]   sel_q;
  logic [2:0]      cti_q;
  logic [7:0]      cnt_q;
  logic [TW-1:0]   tag_q;
  logic [WDW-1:0]  wdog_q;
  logic            done_valid_q, done_err_q;
  logic [TW-1:0]   done_tag_q;

  logic            ack_v, last_v, wdog_hit, cmd_acc, wr_acc;
  logic [7:0]      cnt_d;

  // Acks are only meaningful while a strobe is outstanding.
  assign ack_v    = stb_q & wb_ack_i;
  assign last_v   = ack_v & (cnt_q == 8'd1);
  assign wdog_hit = stb_q & ~wb_ack_i & (wdog_q == WDW'(TO_CYC - 1));
  assign cnt_d    = ack_v ? cnt_q - 8'd1 : cnt_q;

  assign cmd_ready = RESETN & sdr_init_done & (state_q == IDLE);
  assign wr_ready  = RESETN & (state_q == WR) & (~stb_q | wb_ack_i) & ~last_v;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign wr_acc    = wr_valid & wr_ready;

  assign rd_valid = (state_q == RD) & ack_v;
  assign rd_last  = rd_valid & (cnt_q == 8'd1);
  assign rd_data  = rd_valid ? wb_dat_i : '0;
  assign rd_tag   = tag_q;

  assign busy       = (state_q != IDLE);
  assign done_valid = done_valid_q;
  assign done_tag   = done_tag_q;
  assign done_err   = done_err_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_addr_o  = addr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_cti_o   = cti_q;

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      state_q      <= IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      cti_q        <= 3'b000;
      cnt_q        <= 8'd0;
      tag_q        <= '0;
      wdog_q       <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_tag_q   <= '0;
    end else begin
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_tag_q   <= '0;
      case (state_q)
        IDLE: begin
          if (cmd_acc) begin
            addr_q <= cmd_addr;
            tag_q  <= cmd_tag;
            we_q   <= cmd_we;
            cnt_q  <= (cmd_len == 8'd0) ? 8'd1 : cmd_len;
            cti_q  <= (cmd_len <= 8'd1) ? CTI_END : CTI_INC;
            cyc_q  <= 1'b1;
            wdog_q <= '0;
            if (cmd_we) begin
              state_q <= WR;
              stb_q   <= 1'b0;
            end else begin
              state_q <= RD;
              stb_q   <= 1'b1;
              sel_q   <= '1;
            end
          end
        end
        WR, RD: begin
          if (ack_v) begin
            addr_q <= addr_q + AW'(SW);
            cnt_q  <= cnt_d;
            wdog_q <= '0;
          end else if (stb_q) begin
            wdog_q <= wdog_q + WDW'(1);
          end
          if (last_v || wdog_hit) begin
            // Final ack or watchdog expiry: close the cycle and report once.
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            cti_q        <= 3'b000;
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_tag_q   <= tag_q;
            done_err_q   <= wdog_hit;
          end else if (state_q == WR) begin
            if (wr_acc) begin
              dat_q <= wr_data;
              sel_q <= wr_sel;
              stb_q <= 1'b1;
              cti_q <= (cnt_d == 8'd1) ? CTI_END : CTI_INC;
            end else if (ack_v) begin
              stb_q <= 1'b0;
            end
          end else if (ack_v) begin
            cti_q <= (cnt_d == 8'd1) ? CTI_END : CTI_INC;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: drives bus and command ports cycle by
// cycle from tasks and compares against hand-computed values.
module tb_wb_burst_master;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int TO = 16;

  logic            sys_clk = 1'b0;
  logic            RESETN = 1'b0;
  logic            sdr_init_done = 1'b0;
  logic            busy;
  logic            cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [7:0]      cmd_len = '0;
  logic [TW-1:0]   cmd_tag = '0;
  logic            wr_valid = 1'b0, wr_ready;
  logic [DW-1:0]   wr_data = '0;
  logic [DW/8-1:0] wr_sel = '0;
  logic            rd_valid, rd_last;
  logic [DW-1:0]   rd_data;
  logic [TW-1:0]   rd_tag;
  logic            done_valid, done_err;
  logic [TW-1:0]   done_tag;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i = 1'b0;
  logic [DW-1:0]   wb_dat_i = '0;

  int checks = 0;
  int failures = 0;

  wire [122:0] all_out = {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_addr_o, wb_dat_o,
                          wb_sel_o, busy, cmd_ready, wr_ready, done_valid, done_err,
                          done_tag, rd_valid, rd_last, rd_data, rd_tag};

  wb_burst_master #(.DW(DW), .AW(AW), .TW(TW), .TO_CYC(TO)) dut (
    .sys_clk(sys_clk), .RESETN(RESETN), .sdr_init_done(sdr_init_done), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_tag(cmd_tag),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag), .rd_last(rd_last),
    .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  // Presents a command on a negedge; it is accepted on the following posedge.
  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [TW-1:0] tag);
    cmd_we = we; cmd_addr = a; cmd_len = len; cmd_tag = tag; cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; sdr_init_done = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    RESETN = 1'b1; #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      failures++; $display("FAIL reset_release got=%b exp=10", {cmd_ready, busy});
    end
    @(negedge sys_clk);
  endtask

  task automatic test_init_gating();
    int bad = 0;
    sdr_init_done = 1'b0;
    cmd_we = 1'b0; cmd_addr = 26'h40; cmd_len = 8'd1; cmd_tag = 8'h11; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (cmd_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL init_gate_blocked got=%0d exp=0", bad);
    end
    sdr_init_done = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL init_gate_ready got=%b exp=1", cmd_ready);
    end
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_cti_o, busy} !== {3'b110, 26'h40, 3'b111, 1'b1}) begin
      failures++;
      $display("FAIL init_accept got=%h exp=%h", {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_cti_o, busy},
               {3'b110, 26'h40, 3'b111, 1'b1});
    end
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_0040; #1;
    checks++;
    if ({rd_valid, rd_last, rd_data, rd_tag} !== {2'b11, 32'hCAFE_0040, 8'h11}) begin
      failures++; $display("FAIL single_read_beat got=%h exp=%h", {rd_valid, rd_last, rd_data, rd_tag},
                           {2'b11, 32'hCAFE_0040, 8'h11});
    end
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++;
    if ({wb_cyc_o, wb_stb_o, done_valid, done_tag, done_err, cmd_ready} !== {3'b001, 8'h11, 2'b00}) begin
      failures++; $display("FAIL single_read_done got=%h exp=%h",
                           {wb_cyc_o, wb_stb_o, done_valid, done_tag, done_err, cmd_ready}, {3'b001, 8'h11, 2'b00});
    end
    @(negedge sys_clk);
    checks++;
    if ({done_valid, busy, cmd_ready} !== 3'b001) begin
      failures++; $display("FAIL single_read_idle got=%b exp=001", {done_valid, busy, cmd_ready});
    end
  endtask

  task automatic test_write_burst();
    logic [AW-1:0] ea;
    send_cmd(1'b1, 26'h100, 8'd4, 8'h22);
    wr_valid = 1'b1; wr_data = 32'hA000_0000; wr_sel = 4'hF; #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++; $display("FAIL wr_first_ready got=%b exp=1", wr_ready);
    end
    @(negedge sys_clk);
    for (int k = 0; k < 4; k++) begin
      ea = AW'(32'h100 + 4 * k);
      checks++;
      if ({wb_stb_o, wb_cyc_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !==
          {3'b111, ea, 32'hA000_0000 + k, 4'hF, (k == 3) ? 3'b111 : 3'b010}) begin
        failures++;
        $display("FAIL wr_beat%0d got=%h exp=%h", k,
                 {wb_stb_o, wb_cyc_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o},
                 {3'b111, ea, 32'hA000_0000 + k, 4'hF, (k == 3) ? 3'b111 : 3'b010});
      end
      wb_ack_i = 1'b1;
      if (k < 3) wr_data = 32'hA000_0000 + k + 1;
      else wr_valid = 1'b0;
      #1;
      checks++;
      if (wr_ready !== (k < 3)) begin
        failures++; $display("FAIL wr_ready_beat%0d got=%b exp=%b", k, wr_ready, (k < 3));
      end
      @(negedge sys_clk);
    end
    wb_ack_i = 1'b0;
    checks++;
    if ({wb_cyc_o, wb_stb_o, done_valid, done_tag, done_err} !== {3'b001, 8'h22, 1'b0}) begin
      failures++; $display("FAIL wr_done got=%h exp=%h",
                           {wb_cyc_o, wb_stb_o, done_valid, done_tag, done_err}, {3'b001, 8'h22, 1'b0});
    end
    @(negedge sys_clk);
    checks++;
    if ({done_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL wr_done_pulse got=%b exp=00", {done_valid, busy});
    end
  endtask

  task automatic test_read_burst();
    int beats = 0, pulses = 0;
    logic phase = 1'b0;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    send_cmd(1'b0, 26'h200, 8'd8, 8'h33);
    for (int c = 0; c < 40 && beats < 8; c++) begin
      ea = AW'(32'h200 + 4 * beats);
      ed = 32'hD000_0000 | {6'd0, ea};
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_cti_o} !==
          {3'b110, 4'hF, ea, (beats == 7) ? 3'b111 : 3'b010}) begin
        failures++;
        $display("FAIL rd_bus_c%0d got=%h exp=%h", c, {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_cti_o},
                 {3'b110, 4'hF, ea, (beats == 7) ? 3'b111 : 3'b010});
      end
      wb_ack_i = phase; wb_dat_i = phase ? ed : 32'hFFFF_FFFF; #1;
      checks++;
      if (phase) begin
        if (rd_valid === 1'b1) pulses++;
        if ({rd_valid, rd_last, rd_data, rd_tag} !== {1'b1, beats == 7, ed, 8'h33}) begin
          failures++; $display("FAIL rd_beat%0d got=%h exp=%h", beats, {rd_valid, rd_last, rd_data, rd_tag},
                               {1'b1, beats == 7, ed, 8'h33});
        end
        beats++;
      end else if (rd_valid !== 1'b0) begin
        failures++; $display("FAIL rd_idle_c%0d got=%b exp=0", c, rd_valid);
      end
      phase = ~phase;
      @(negedge sys_clk);
    end
    wb_ack_i = 1'b0;
    checks++;
    if (pulses != 8) begin
      failures++; $display("FAIL rd_pulse_count got=%0d exp=8", pulses);
    end
    checks++;
    if ({wb_cyc_o, done_valid, done_tag, done_err} !== {2'b01, 8'h33, 1'b0}) begin
      failures++; $display("FAIL rd_done got=%h exp=%h", {wb_cyc_o, done_valid, done_tag, done_err},
                           {2'b01, 8'h33, 1'b0});
    end
    @(negedge sys_clk);
  endtask

  task automatic test_wr_starve();
    send_cmd(1'b1, 26'h300, 8'd3, 8'h44);
    wr_valid = 1'b1; wr_data = 32'hE000_0000; wr_sel = 4'hC;
    @(negedge sys_clk);
    wb_ack_i = 1'b1; wr_valid = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({wb_stb_o, wb_cyc_o, wb_addr_o, wr_ready} !== {2'b01, 26'h304, 1'b1}) begin
        failures++; $display("FAIL starve_hold%0d got=%h exp=%h", i, {wb_stb_o, wb_cyc_o, wb_addr_o, wr_ready},
                             {2'b01, 26'h304, 1'b1});
      end
      wb_ack_i = (i == 2);
      @(negedge sys_clk);
    end
    checks++;
    if ({wb_stb_o, wb_cyc_o, wb_addr_o} !== {2'b01, 26'h304}) begin
      failures++; $display("FAIL starve_stray_ack got=%h exp=%h", {wb_stb_o, wb_cyc_o, wb_addr_o}, {2'b01, 26'h304});
    end
    wb_ack_i = 1'b0; wr_valid = 1'b1; wr_data = 32'hE000_0001;
    @(negedge sys_clk);
    checks++;
    if ({wb_stb_o, wb_addr_o, wb_dat_o, wb_cti_o} !== {1'b1, 26'h304, 32'hE000_0001, 3'b010}) begin
      failures++; $display("FAIL starve_beat1 got=%h exp=%h", {wb_stb_o, wb_addr_o, wb_dat_o, wb_cti_o},
                           {1'b1, 26'h304, 32'hE000_0001, 3'b010});
    end
    wb_ack_i = 1'b1; wr_data = 32'hE000_0002;
    @(negedge sys_clk);
    checks++;
    if ({wb_stb_o, wb_addr_o, wb_dat_o, wb_cti_o} !== {1'b1, 26'h308, 32'hE000_0002, 3'b111}) begin
      failures++; $display("FAIL starve_beat2 got=%h exp=%h", {wb_stb_o, wb_addr_o, wb_dat_o, wb_cti_o},
                           {1'b1, 26'h308, 32'hE000_0002, 3'b111});
    end
    wr_valid = 1'b0;
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++;
    if ({wb_cyc_o, done_valid, done_tag, done_err} !== {2'b01, 8'h44, 1'b0}) begin
      failures++; $display("FAIL starve_done got=%h exp=%h", {wb_cyc_o, done_valid, done_tag, done_err},
                           {2'b01, 8'h44, 1'b0});
    end
    @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    int n = 0;
    send_cmd(1'b0, 26'h400, 8'd2, 8'h55);
    for (int i = 0; i < 100 && wb_cyc_o === 1'b1; i++) begin
      n++;
      @(negedge sys_clk);
    end
    checks++;
    if (n != TO) begin
      failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO);
    end
    checks++;
    if ({wb_cyc_o, wb_stb_o, done_valid, done_tag, done_err} !== {3'b001, 8'h55, 1'b1}) begin
      failures++; $display("FAIL timeout_done got=%h exp=%h", {wb_cyc_o, wb_stb_o, done_valid, done_tag, done_err},
                           {3'b001, 8'h55, 1'b1});
    end
    @(negedge sys_clk);
    send_cmd(1'b0, 26'h410, 8'd1, 8'h56);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0410;
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++;
    if ({done_valid, done_tag, done_err} !== {1'b1, 8'h56, 1'b0}) begin
      failures++; $display("FAIL timeout_next_cmd got=%h exp=%h", {done_valid, done_tag, done_err},
                           {1'b1, 8'h56, 1'b0});
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send_cmd(1'b0, 26'h500, 8'd8, 8'h66);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({wb_stb_o, wb_addr_o} !== {1'b1, 26'h508}) begin
      failures++; $display("FAIL rst_mid_beat3 got=%h exp=%h", {wb_stb_o, wb_addr_o}, {1'b1, 26'h508});
    end
    RESETN = 1'b0;
    @(negedge sys_clk);
    wb_ack_i = 1'b0; #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0", all_out);
    end
    RESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      if (done_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", bad);
    end
    send_cmd(1'b1, 26'h600, 8'd2, 8'h77);
    wr_valid = 1'b1; wr_data = 32'hF000_0000; wr_sel = 4'hF;
    @(negedge sys_clk);
    wb_ack_i = 1'b1; wr_data = 32'hF000_0001;
    @(negedge sys_clk);
    checks++;
    if ({wb_stb_o, wb_addr_o, wb_dat_o, wb_cti_o} !== {1'b1, 26'h604, 32'hF000_0001, 3'b111}) begin
      failures++; $display("FAIL rst_mid_new_beat got=%h exp=%h", {wb_stb_o, wb_addr_o, wb_dat_o, wb_cti_o},
                           {1'b1, 26'h604, 32'hF000_0001, 3'b111});
    end
    wr_valid = 1'b0;
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++;
    if ({done_valid, done_tag, done_err} !== {1'b1, 8'h77, 1'b0}) begin
      failures++; $display("FAIL rst_mid_new_done got=%h exp=%h", {done_valid, done_tag, done_err},
                           {1'b1, 8'h77, 1'b0});
    end
    @(negedge sys_clk);
  endtask

  task automatic test_wrap_init();
    send_cmd(1'b0, 26'h3FF_FFFC, 8'd2, 8'h99);
    sdr_init_done = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0001;
    @(negedge sys_clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_addr_o, wb_cti_o} !== {2'b11, 26'h0, 3'b111}) begin
      failures++; $display("FAIL wrap_addr got=%h exp=%h", {wb_cyc_o, wb_stb_o, wb_addr_o, wb_cti_o},
                           {2'b11, 26'h0, 3'b111});
    end
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++;
    if ({done_valid, done_tag, done_err} !== {1'b1, 8'h99, 1'b0}) begin
      failures++; $display("FAIL wrap_done got=%h exp=%h", {done_valid, done_tag, done_err}, {1'b1, 8'h99, 1'b0});
    end
    @(negedge sys_clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b00) begin
      failures++; $display("FAIL init_low_blocked got=%b exp=00", {cmd_ready, busy});
    end
    sdr_init_done = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL init_return_ready got=%b exp=1", cmd_ready);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_len0();
    send_cmd(1'b1, 26'h700, 8'd0, 8'h88);
    wr_valid = 1'b1; wr_data = 32'h1234_5678; wr_sel = 4'h3;
    @(negedge sys_clk);
    checks++;
    if ({wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== {2'b11, 26'h700, 32'h1234_5678, 4'h3, 3'b111}) begin
      failures++; $display("FAIL len0_beat got=%h exp=%h", {wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o},
                           {2'b11, 26'h700, 32'h1234_5678, 4'h3, 3'b111});
    end
    wr_valid = 1'b0; wb_ack_i = 1'b1; #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++; $display("FAIL len0_final_ready got=%b exp=0", wr_ready);
    end
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++;
    if ({wb_cyc_o, done_valid, done_tag, done_err} !== {2'b01, 8'h88, 1'b0}) begin
      failures++; $display("FAIL len0_done got=%h exp=%h", {wb_cyc_o, done_valid, done_tag, done_err},
                           {2'b01, 8'h88, 1'b0});
    end
    @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_write_burst();
    test_read_burst();
    test_wr_starve();
    test_timeout();
    test_reset_mid();
    test_wrap_init();
    test_len0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter DW, default 32, application/Wishbone data width.
REQ-002 SHALL have parameter AW, default 26, Wishbone byte-address width.
REQ-003 SHALL have parameter TW, default 8, command tag width.
REQ-004 SHALL have parameter TO_CYC, default 1024, ack watchdog limit in cycles.
REQ-005 SHALL have ports: sys_clk in 1 clock; RESETN in 1 reset (one clock, synchronous, active-low).
REQ-006 SHALL have ports: sdr_init_done in 1, controller init complete; busy out 1, burst in progress.
REQ-007 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_we in 1; cmd_addr in AW; cmd_len in 8 (beats, 0 treated as 1); cmd_tag in TW.
REQ-008 SHALL have ports: wr_valid in 1; wr_ready out 1; wr_data in DW; wr_sel in DW/8.
REQ-009 SHALL have ports: rd_valid out 1; rd_data out DW; rd_tag out TW; rd_last out 1 (no backpressure).
REQ-010 SHALL have ports: done_valid out 1; done_tag out TW; done_err out 1.
REQ-011 SHALL have ports: wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_addr_o out AW; wb_dat_o out DW; wb_sel_o out DW/8; wb_cti_o out 3; wb_ack_i in 1; wb_dat_i in DW.

Function
REQ-012 SHALL implement FSM states IDLE, WR, RD, DONE.
REQ-013 SHALL assert cmd_ready only in IDLE with sdr_init_done=1; command accepted on cmd_valid&cmd_ready.
REQ-014 SHALL on accept latch addr/tag/we, load beat counter with max(cmd_len,1), enter WR (we=1) or RD (we=0), and assert wb_cyc_o next cycle.
REQ-015 SHALL hold wb_cyc_o=1 continuously from first beat until final ack or timeout.
REQ-016 WR: wr_ready=1 when stb is low or ack this cycle; a beat is loaded on wr_valid&wr_ready into wb_dat_o/wb_sel_o with wb_stb_o=1 next cycle.
REQ-017 WR: if no write data available, wb_stb_o SHALL drop (wait state) with cyc held; data/addr stable while stb=1 and ack=0.
REQ-018 RD: wb_stb_o=1 every cycle of burst, wb_sel_o all ones, wb_we_o=0.
REQ-019 RD: each ack SHALL produce rd_valid=1 same cycle (registered-through combinational of wb_dat_i into rd_data), rd_tag=latched tag, rd_last=1 on final beat.
REQ-020 Each ack SHALL advance wb_addr_o by DW/8, wrapping modulo 2^AW, and decrement beat counter.
REQ-021 wb_cti_o SHALL be 3'b010 on non-final beats, 3'b111 on final beat (and single-beat bursts).
REQ-022 After final ack, SHALL drop cyc/stb next cycle, enter DONE, pulse done_valid one cycle with done_tag, done_err=0, then return to IDLE (earliest next accept 1 cycle after done).
REQ-023 Watchdog SHALL count cycles with stb=1 and no ack; reset on each ack; at TO_CYC SHALL drop cyc/stb, enter DONE with done_err=1, discard remaining beats.
REQ-024 wb_ack_i while wb_stb_o=0 SHALL be ignored.
REQ-025 busy SHALL be 1 in WR, RD, DONE.
REQ-026 sdr_init_done falling mid-burst SHALL NOT abort; new commands blocked until it returns high.

Reset
REQ-027 With RESETN=0 at sys_clk edge: state IDLE; all outputs 0 (wb_cti_o=0, addr/data 0); counters cleared; in-flight burst abandoned with no done pulse.
REQ-028 Reset SHALL take effect only on sys_clk edge; outputs valid from first edge with RESETN=1.

Verification
REQ-029 Init gating: sdr_init_done=0, cmd_valid=1 -> cmd_ready=0 for 100 cycles; raise -> accepted next cycle.
REQ-030 Write burst: addr 0x100, len 4, 0-wait ack -> 4 beats at 0x100/104/108/10C, cti 010,010,010,111, done_tag matches, err=0.
REQ-031 Read burst with 2-cycle ack spacing, len 8 -> 8 rd_valid pulses, data matches memory, rd_last only on beat 8.
REQ-032 Write data starvation: wr_valid low 5 cycles mid-burst -> stb low, cyc high, addr held; burst completes correctly.
REQ-033 No ack for TO_CYC cycles -> cyc drops, done_valid=1, done_err=1, next command accepted.
REQ-034 RESETN low mid read burst (beat 3 of 8) -> next cycle all outputs 0, no done pulse; new command completes normally.
